// File: rtl/rca_sweep_ctrl_if.sv
// Adder self-test bus: adder drive/sense plus display and status outputs.
// master = sweep controller, slave = adder/display side.
interface rca_sweep_ctrl_if;
  logic       start;
  logic       hold;
  logic [3:0] sum_in;
  logic [2:0] op_a;
  logic [2:0] op_b;
  logic [3:0] hex3;
  logic [3:0] hex2;
  logic [3:0] hex1;
  logic [3:0] hex0;
  logic [6:0] err_cnt;
  logic       busy;
  logic       done;

  modport master (
    input  start, hold, sum_in,
    output op_a, op_b, hex3, hex2, hex1, hex0, err_cnt, busy, done
  );

  modport slave (
    output start, hold, sum_in,
    input  op_a, op_b, hex3, hex2, hex1, hex0, err_cnt, busy, done
  );
endinterface

// File: rtl/rca_sweep_ctrl.sv
// Sweeps a 3-bit adder through all 64 operand pairs, checks each sum after one
// settle cycle, shows each vector for DWELL cycles and finally the error count.
module rca_sweep_ctrl #(
  parameter int DWELL   = 50_000_000,
  parameter int DWELL_W = 26
) (
  input  logic              clk,
  input  logic              reset,
  rca_sweep_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SAMPLE = 3'd2,
    S_DWELL  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [5:0]           idx_q, idx_d;
  logic [6:0]           err_q, err_d;
  logic [3:0]           hex3_q, hex3_d, hex2_q, hex2_d, hex1_q, hex1_d, hex0_q, hex0_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [DWELL_W-1:0]   timer_q, timer_d;

  logic [3:0] exp_sum;
  logic [3:0] pop_cnt;
  logic       dwell_end;

  assign exp_sum   = {1'b0, idx_q[5:3]} + {1'b0, idx_q[2:0]};
  assign pop_cnt   = {3'b000, bus.sum_in[0]} + {3'b000, bus.sum_in[1]}
                   + {3'b000, bus.sum_in[2]} + {3'b000, bus.sum_in[3]};
  assign dwell_end = !bus.hold && (timer_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bus.start) state_d = S_APPLY;
      S_APPLY:        state_d = S_SAMPLE;
      S_SAMPLE:       state_d = S_DWELL;
      S_DWELL:        if (dwell_end) state_d = (idx_q == 6'h3F) ? S_DONE : S_APPLY;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    err_d   = err_q;
    hex3_d  = hex3_q;
    hex2_d  = hex2_q;
    hex1_d  = hex1_q;
    hex0_d  = hex0_q;
    busy_d  = busy_q;
    done_d  = done_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          idx_d  = '0;
          err_d  = '0;
          busy_d = 1'b1;
          done_d = 1'b0;
        end
      end
      S_SAMPLE: begin
        if ((bus.sum_in != exp_sum) && (err_q != 7'd64)) err_d = err_q + 7'd1;
        hex3_d  = {1'b0, idx_q[5:3]};
        hex2_d  = {1'b0, idx_q[2:0]};
        hex1_d  = bus.sum_in;
        hex0_d  = pop_cnt;
        timer_d = DWELL_W'(DWELL - 1);
      end
      S_DWELL: begin
        if (!bus.hold) begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else if (idx_q == 6'h3F) begin
            // Final display: "EE" marker followed by the error count in hex.
            busy_d = 1'b0;
            done_d = 1'b1;
            hex3_d = 4'hE;
            hex2_d = 4'hE;
            hex1_d = {1'b0, err_q[6:4]};
            hex0_d = err_q[3:0];
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      err_q   <= '0;
      hex3_q  <= '0;
      hex2_q  <= '0;
      hex1_q  <= '0;
      hex0_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      idx_q   <= idx_d;
      err_q   <= err_d;
      hex3_q  <= hex3_d;
      hex2_q  <= hex2_d;
      hex1_q  <= hex1_d;
      hex0_q  <= hex0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      timer_q <= timer_d;
    end
  end

  assign bus.op_a    = idx_q[5:3];
  assign bus.op_b    = idx_q[2:0];
  assign bus.hex3    = hex3_q;
  assign bus.hex2    = hex2_q;
  assign bus.hex1    = hex1_q;
  assign bus.hex0    = hex0_q;
  assign bus.err_cnt = err_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_rca_sweep_ctrl.sv
// Directed bench: clean sweeps (with start pulse, restart and hold), a stuck-bit
// adder sweep, and a mid-sweep reset with start also high.
module tb_rca_sweep_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rca_sweep_ctrl_if ifc4 ();
  rca_sweep_ctrl_if ifc2 ();

  assign ifc4.sum_in = {1'b0, ifc4.op_a} + {1'b0, ifc4.op_b};
  assign ifc2.sum_in = ({1'b0, ifc2.op_a} + {1'b0, ifc2.op_b}) & 4'b1110;

  rca_sweep_ctrl #(.DWELL(4), .DWELL_W(26)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc4.master)
  );

  rca_sweep_ctrl #(.DWELL(2), .DWELL_W(26)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc2.master)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vector k of the DWELL=4 instance occupies edges t+6k .. t+6k+5; a hold
  // of hold_len cycles is applied at the start of vector 10's dwell.
  task automatic sweep4(input int hold_len, input int pulse_at);
    int c;
    int e;
    int done_at;
    done_at = 384 + hold_len;
    ifc4.start = 1'b1;
    tick();
    ifc4.start = 1'b0;
    chk("s4_busy_t0", 32'(ifc4.busy), 32'd1);
    chk("s4_done_t0", 32'(ifc4.done), 32'd0);
    chk("s4_err_t0",  32'(ifc4.err_cnt), 32'd0);
    chk("s4_idx_t0",  32'({ifc4.op_a, ifc4.op_b}), 32'd0);
    c = 0;
    while (c < done_at + 3) begin
      tick();
      c++;
      if (c == pulse_at)     ifc4.start = 1'b1;
      if (c == pulse_at + 2) ifc4.start = 1'b0;
      if (hold_len > 0 && c == 62)            ifc4.hold = 1'b1;
      if (hold_len > 0 && c == 62 + hold_len) ifc4.hold = 1'b0;
      if (hold_len == 0 || c <= 62)   e = c / 6;
      else if (c <= 62 + hold_len)    e = 10;
      else                            e = (c - hold_len) / 6;
      if (e > 63) e = 63;
      chk("s4_idx",  32'({ifc4.op_a, ifc4.op_b}), 32'(e));
      chk("s4_done", 32'(ifc4.done), 32'(c >= done_at));
      chk("s4_busy", 32'(ifc4.busy), 32'(c < done_at));
      if (c == 2) begin
        chk("s4_v00_hex", 32'({ifc4.hex3, ifc4.hex2, ifc4.hex1, ifc4.hex0}), 32'h0000);
      end
      if (c == 380 + hold_len) begin
        chk("s4_v77_hex", 32'({ifc4.hex3, ifc4.hex2, ifc4.hex1, ifc4.hex0}), 32'h77E3);
      end
    end
    chk("s4_final_hex", 32'({ifc4.hex3, ifc4.hex2, ifc4.hex1, ifc4.hex0}), 32'hEE00);
    chk("s4_final_err", 32'(ifc4.err_cnt), 32'd0);
  endtask

  task automatic sweep2();
    int c;
    ifc2.start = 1'b1;
    tick();
    ifc2.start = 1'b0;
    chk("s2_busy_t0", 32'(ifc2.busy), 32'd1);
    chk("s2_done_t0", 32'(ifc2.done), 32'd0);
    chk("s2_err_t0",  32'(ifc2.err_cnt), 32'd0);
    chk("s2_idx_t0",  32'({ifc2.op_a, ifc2.op_b}), 32'd0);
    for (c = 1; c <= 258; c++) begin
      tick();
      chk("s2_done", 32'(ifc2.done), 32'(c >= 256));
    end
    chk("s2_err",  32'(ifc2.err_cnt), 32'd32);
    chk("s2_hex",  32'({ifc2.hex3, ifc2.hex2, ifc2.hex1, ifc2.hex0}), 32'hEE20);
    chk("s2_ops",  32'({ifc2.op_a, ifc2.op_b}), 32'h3F);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    ifc4.start = 1'b0;
    ifc4.hold  = 1'b0;
    ifc2.start = 1'b0;
    ifc2.hold  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_idx",  32'({ifc4.op_a, ifc4.op_b}), 32'd0);
    chk("rst_hex",  32'({ifc4.hex3, ifc4.hex2, ifc4.hex1, ifc4.hex0}), 32'd0);
    chk("rst_err",  32'(ifc4.err_cnt), 32'd0);
    chk("rst_busy", 32'(ifc4.busy), 32'd0);
    chk("rst_done", 32'(ifc4.done), 32'd0);
    tick();
    chk("idle_busy", 32'(ifc4.busy), 32'd0);

    sweep4(0, 100);
    sweep4(0, -10);
    sweep4(10, -10);

    sweep2();
    sweep2();

    // Reset in the middle of vector 0x1A's dwell, with start held high too.
    ifc4.start = 1'b1;
    tick();
    ifc4.start = 1'b0;
    for (c = 1; c <= 159; c++) tick();
    chk("pre_rst_idx", 32'({ifc4.op_a, ifc4.op_b}), 32'h1A);
    chk("pre_rst_hex", 32'({ifc4.hex3, ifc4.hex2, ifc4.hex1, ifc4.hex0}), 32'h3252);
    reset = 1'b1;
    ifc4.start = 1'b1;
    tick();
    chk("mid_rst_idx",  32'({ifc4.op_a, ifc4.op_b}), 32'd0);
    chk("mid_rst_hex",  32'({ifc4.hex3, ifc4.hex2, ifc4.hex1, ifc4.hex0}), 32'd0);
    chk("mid_rst_err",  32'(ifc4.err_cnt), 32'd0);
    chk("mid_rst_busy", 32'(ifc4.busy), 32'd0);
    chk("mid_rst_done", 32'(ifc4.done), 32'd0);
    tick();
    chk("rst_win_busy", 32'(ifc4.busy), 32'd0);
    reset = 1'b0;
    ifc4.start = 1'b0;
    tick();
    chk("post_rst_busy", 32'(ifc4.busy), 32'd0);
    chk("post_rst_idx",  32'({ifc4.op_a, ifc4.op_b}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rca_sweep_ctrl.md
# rca_sweep_ctrl

Self-test sequencer for the 3-bit ripple-carry adder and its 4-digit scanned hex display. It steps the adder through all 64 operand pairs, gives the adder a settle cycle, and checks each result against an internal reference sum. It holds each vector on the display for a programmable dwell and counts mismatches. At the end it shows the error count.

## Interface
Parameters:
- DWELL, 50_000_000: display cycles per vector; must be ≥ 1
- DWELL_W, 26: timer width; must satisfy 2^DWELL_W > DWELL

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  level, sampled in IDLE/DONE only; begins sweep
- hold  in  1  freezes dwell timer while high
- sum_in  in  4  {cout, sum[2:0]} from adder, combinational in op_a/op_b
- op_a  out  3  adder operand a
- op_b  out  3  adder operand b
- hex3  out  4  display digit 3 (leftmost)
- hex2  out  4  display digit 2
- hex1  out  4  display digit 1
- hex0  out  4  display digit 0
- err_cnt  out  7  mismatches this sweep, 0..64
- busy  out  1  sweep in progress
- done  out  1  sweep finished, result valid

## Operation
- All outputs are registered.
- Reset values: op_a=0, op_b=0, hex3..hex0=0, err_cnt=0, busy=0, done=0, state IDLE, timer=0.
- Vector index is {op_a, op_b}, a 6-bit value with op_b as the low bits. It increments 0x00 → 0x3F.
- States:
  - IDLE: busy=0, done=0. If start=1, go to APPLY, clear op_a, op_b and err_cnt, and set busy=1.
  - APPLY: one settle cycle for the adder. No sampling. Go to SAMPLE.
  - SAMPLE: compare sum_in with expected = op_a + op_b (zero-extended to 4 bits).
    - On mismatch, err_cnt += 1. err_cnt cannot exceed 64.
    - Load hex3=op_a, hex2=op_b, hex1=sum_in, hex0=popcount(sum_in) (range 0..4).
    - Load timer = DWELL-1 and go to DWELL.
  - DWELL:
    - If hold=1, the timer does not change.
    - Otherwise, if timer≠0, decrement the timer.
    - Otherwise (timer=0), if index=0x3F go to DONE; else increment the index and go to APPLY.
  - DONE: busy=0, done=1. Display hex3=4'hE, hex2=4'hE, hex1={1'b0, err_cnt[6:4]}, hex0=err_cnt[3:0].
    - op_a and op_b hold 7,7.
    - If start=1, restart exactly as from IDLE, and done drops on the next cycle.
- start is ignored in APPLY, SAMPLE and DWELL.
- hold is ignored outside DWELL.
- reset in any state, including mid-sweep, returns all registers to their reset values on the next edge.

## Timing
- Let start be sampled high at edge t.
  - At t: state=APPLY, busy=1.
  - At t+1: SAMPLE.
  - At t+2: hex/err_cnt for vector 0 are visible, and state=DWELL.
- With hold low, a vector occupies APPLY(1) + SAMPLE(1) + DWELL(DWELL) = DWELL+2 cycles.
- Full sweep: done=1 exactly 64·(DWELL+2) cycles after the edge at which start is sampled. Each hold-high cycle in DWELL adds exactly one cycle.
- sum_in is sampled only in SAMPLE, one full cycle after op_a/op_b change, so the adder's combinational depth has one cycle to settle.
- Boundary cases:
  - DWELL=1: one dwell cycle per vector.
  - Index wrap beyond 0x3F never occurs.
  - If start and reset are both high, reset wins.

## Test plan
- Reset: assert reset for 2 cycles mid-DWELL at vector 0x1A → next cycle all outputs 0, state IDLE, busy=0, done=0.
- Clean sweep: DWELL=4, ideal adder model, pulse start → done=1 exactly 384 cycles later, err_cnt=0, hex3..hex0 = E,E,0,0.
- Fault injection: DWELL=2, adder model with sum bit0 stuck at 0 → err_cnt=32 at done, hex1=2, hex0=0.
- Digit check: at vector a=7, b=7 with an ideal adder → hex3=7, hex2=7, hex1=E, hex0=3. At a=0, b=0 → 0,0,0,0.
- Hold: DWELL=4, hold high for 10 cycles during the DWELL of vector a=1, b=2 → op_a/op_b stay 1/2 throughout, and done arrives at cycle 394 instead of 384.
- Control: start pulsed while busy → no effect on index or err_cnt. After done, start again → done drops, err_cnt=0, op_a=op_b=0, and a second sweep completes identically.
